// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one 256x8 synchronous RAM between the CPU and a loader/DMA master.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module ram_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_data,
    output logic       ram_we,
    input  logic [7:0] ram_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   owner;
    logic   grant1;

`ifdef RAM_ARB_RR_EN
    logic rr_last;

    // A tie goes to the port that was not granted last time.
    always_comb begin
        grant1 = req1 & (~req0 | ~rr_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (state == IDLE && (req0 | req1)) begin
            rr_last <= grant1;
        end
    end
`else
    always_comb begin
        grant1 = req1 & ~req0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req0 | req1) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= 8'h00;
            ram_data <= 8'h00;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= 8'h00;
            rdata1   <= 8'h00;
        end else begin
            ram_we <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        owner    <= grant1;
                        ram_we   <= grant1 ? we1 : we0;
                        ram_addr <= grant1 ? addr1 : addr0;
                        ram_data <= grant1 ? wdata1 : wdata0;
                    end
                end
                ACCESS: begin
                    ack0 <= ~owner;
                    ack1 <= owner;
                    // ram_we still reflects the in-flight transaction type here.
                    if (!ram_we) begin
                        if (owner) rdata1 <= ram_out;
                        else       rdata0 <= ram_out;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
